// File: rtl/taxi_uart_pkg.sv
// Shared definitions for the taxi UART transmitter and receiver.
// The bit period is prescale << PRESCALE_SHIFT clock cycles on both sides.
package taxi_uart_pkg;

  localparam int PRESCALE_SHIFT = 3;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } uart_rx_state_t;

endpackage

// File: rtl/taxi_uart_rx.sv
// UART receiver with an AXI4-Stream style byte output.
// The line is oversampled at prescale*8 clocks per bit. After the start edge the
// receiver waits half a bit, then samples each data bit (LSB first) and the stop
// bit at its midpoint. Good frames are presented on the m_axis_rx_* source
// signals (the tdata/tvalid/tready members of a taxi_axis_if source; the other
// sidebands are not used). A low stop bit raises frame_error. A byte completing
// while the previous one is still waiting raises overrun_error.
module taxi_uart_rx
  import taxi_uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] m_axis_rx_tdata,
  output logic              m_axis_rx_tvalid,
  input  logic              m_axis_rx_tready,
  input  logic              rxd,
  output logic              busy,
  output logic              overrun_error,
  output logic              frame_error,
  input  logic [15:0]       prescale
);

  localparam int CNT_W = 16 + PRESCALE_SHIFT;

  uart_rx_state_t    state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [3:0]        bit_cnt, bit_cnt_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [15:0]       prescale_reg, prescale_next;
  logic [DATA_W-1:0] tdata_next;
  logic              tvalid_next;
  logic              busy_next;
  logic              overrun_next;
  logic              frame_next;
  logic [1:0]        rxd_sync;
  logic              rxd_s;

  // Full bit period minus one, used to reload the bit timer.
  function automatic logic [CNT_W-1:0] bit_ticks_m1(input logic [15:0] ps);
    return (CNT_W'(ps) << PRESCALE_SHIFT) - CNT_W'(1);
  endfunction

  // Half bit period minus one, so the first sample lands mid start bit.
  function automatic logic [CNT_W-1:0] half_ticks_m1(input logic [15:0] ps);
    return (CNT_W'(ps) << (PRESCALE_SHIFT - 1)) - CNT_W'(1);
  endfunction

  assign rxd_s = rxd_sync[1];

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_sync <= 2'b11;
    end else begin
      rxd_sync <= {rxd_sync[0], rxd};
    end
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RX_IDLE;
      cnt              <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      prescale_reg     <= '0;
      m_axis_rx_tdata  <= '0;
      m_axis_rx_tvalid <= 1'b0;
      busy             <= 1'b0;
      overrun_error    <= 1'b0;
      frame_error      <= 1'b0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      bit_cnt          <= bit_cnt_next;
      shreg            <= shreg_next;
      prescale_reg     <= prescale_next;
      m_axis_rx_tdata  <= tdata_next;
      m_axis_rx_tvalid <= tvalid_next;
      busy             <= busy_next;
      overrun_error    <= overrun_next;
      frame_error      <= frame_next;
    end
  end

  // Frame sequencing, bit timing and output handshake.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bit_cnt_next  = bit_cnt;
    shreg_next    = shreg;
    prescale_next = prescale_reg;
    tdata_next    = m_axis_rx_tdata;
    tvalid_next   = m_axis_rx_tvalid;
    busy_next     = busy;
    overrun_next  = 1'b0;
    frame_next    = 1'b0;

    if (m_axis_rx_tvalid && m_axis_rx_tready) begin
      tvalid_next = 1'b0;
    end

    case (state)
      RX_IDLE: begin
        if (prescale != 16'd0 && !rxd_s) begin
          prescale_next = prescale;
          cnt_next      = half_ticks_m1(prescale);
          busy_next     = 1'b1;
          state_next    = RX_START;
        end
      end
      RX_START: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else if (!rxd_s) begin
          cnt_next     = bit_ticks_m1(prescale_reg);
          bit_cnt_next = 4'(DATA_W);
          state_next   = RX_DATA;
        end else begin
          busy_next  = 1'b0;
          state_next = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          shreg_next   = {rxd_s, shreg[DATA_W-1:1]};
          bit_cnt_next = bit_cnt - 4'd1;
          cnt_next     = bit_ticks_m1(prescale_reg);
          if (bit_cnt == 4'd1) begin
            state_next = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          busy_next = 1'b0;
          if (rxd_s) begin
            tdata_next   = shreg;
            tvalid_next  = 1'b1;
            overrun_next = m_axis_rx_tvalid && !m_axis_rx_tready;
            state_next   = RX_IDLE;
          end else begin
            frame_next = 1'b1;
            state_next = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        if (rxd_s) begin
          state_next = RX_IDLE;
        end
      end
      default: begin
        state_next = RX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_taxi_uart_rx.sv
// Self-checking bench for taxi_uart_rx: serial frames are driven onto rxd and the
// delivered bytes, error pulses and busy timing are compared with expectations
// derived from the frame format.
module tb_taxi_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        rxd;
  logic        busy;
  logic        overrun_error;
  logic        frame_error;
  logic [15:0] prescale;

  int passed = 0;
  int total  = 0;

  int          cyc = 0;
  int          drive_cyc;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          fe_pulses, fe_high, ov_pulses, ov_high;
  int          busy_rises, busy_run, last_busy_len, busy_rise_cyc;
  logic        busy_prev = 1'b0;
  logic        fe_prev = 1'b0;
  logic        ov_prev = 1'b0;
  logic        fall_tvalid;

  taxi_uart_rx #(.DATA_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m_axis_rx_tdata  (tdata),
    .m_axis_rx_tvalid (tvalid),
    .m_axis_rx_tready (tready),
    .rxd              (rxd),
    .busy             (busy),
    .overrun_error    (overrun_error),
    .frame_error      (frame_error),
    .prescale         (prescale)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: collects accepted bytes, pulse counts and busy timing.
  initial begin
    forever begin
      @(negedge clk);
      if (tvalid === 1'b1 && tready === 1'b1) got_q.push_back(tdata);
      if (frame_error === 1'b1) begin
        fe_high++;
        if (!fe_prev) fe_pulses++;
      end
      fe_prev = (frame_error === 1'b1);
      if (overrun_error === 1'b1) begin
        ov_high++;
        if (!ov_prev) ov_pulses++;
      end
      ov_prev = (overrun_error === 1'b1);
      if (busy === 1'b1) begin
        if (!busy_prev) begin
          busy_rises++;
          busy_rise_cyc = cyc;
        end
        busy_run++;
      end else if (busy_prev) begin
        last_busy_len = busy_run;
        busy_run      = 0;
        fall_tvalid   = tvalid;
      end
      busy_prev = (busy === 1'b1);
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d passed of %0d", passed, total);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    fe_pulses     = 0;
    fe_high       = 0;
    ov_pulses     = 0;
    ov_high       = 0;
    busy_rises    = 0;
    busy_run      = 0;
    last_busy_len = -1;
    busy_rise_cyc = -1;
    fall_tvalid   = 1'b0;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; the line is left at stop_val.
  task automatic send_frame(input logic [7:0] data, input logic stop_val, input int bit_clks);
    rxd       = 1'b0;
    drive_cyc = cyc;
    tick(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      tick(bit_clks);
    end
    rxd = stop_val;
    tick(bit_clks);
  endtask

  task automatic compare_bytes(input string name);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      $display("[TB] FAIL %s count: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
    end else passed++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        $display("[TB] FAIL %s byte %0d: got %h, expected %h", name, i, got_q[i], exp_q[i]);
      end else passed++;
    end
  endtask

  task automatic check_no_errors(input string name);
    total++;
    if (fe_pulses !== 0) $display("[TB] FAIL %s frame_error: got %0d pulses, expected 0", name, fe_pulses);
    else passed++;
    total++;
    if (ov_pulses !== 0) $display("[TB] FAIL %s overrun_error: got %0d pulses, expected 0", name, ov_pulses);
    else passed++;
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if (tvalid !== 1'b0) $display("[TB] FAIL %s tvalid: got %b, expected 0", name, tvalid);
    else passed++;
    total++;
    if (tdata !== 8'h00) $display("[TB] FAIL %s tdata: got %h, expected 00", name, tdata);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("[TB] FAIL %s busy: got %b, expected 0", name, busy);
    else passed++;
    total++;
    if (frame_error !== 1'b0) $display("[TB] FAIL %s frame_error: got %b, expected 0", name, frame_error);
    else passed++;
    total++;
    if (overrun_error !== 1'b0) $display("[TB] FAIL %s overrun_error: got %b, expected 0", name, overrun_error);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rxd      = 1'b1;
    tready   = 1'b1;
    prescale = 16'd4;
    tick(5);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_basic_frame();
    clear_mon();
    prescale = 16'd4;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 32);
    tick(64);
    compare_bytes("basic");
    check_no_errors("basic");
    // Pin driven after an edge: first synchronizer flop, second flop, then the registered detect.
    total++;
    if (busy_rise_cyc - drive_cyc !== 3)
      $display("[TB] FAIL basic start latency: got %0d clk, expected 3", busy_rise_cyc - drive_cyc);
    else passed++;
    // Half a start bit plus 8 data bits plus the stop bit up to its midpoint: 9.5 * 32.
    total++;
    if (last_busy_len !== 304) $display("[TB] FAIL basic busy length: got %0d, expected 304", last_busy_len);
    else passed++;
    total++;
    if (fall_tvalid !== 1'b1) $display("[TB] FAIL basic tvalid at stop sample: got %b, expected 1", fall_tvalid);
    else passed++;
    total++;
    if (tvalid !== 1'b0) $display("[TB] FAIL basic tvalid after transfer: got %b, expected 0", tvalid);
    else passed++;
  endtask

  task automatic test_start_glitch();
    clear_mon();
    rxd = 1'b0;
    tick(10);
    rxd = 1'b1;
    tick(64);
    total++;
    if (busy_rises !== 1) $display("[TB] FAIL glitch busy rises: got %0d, expected 1", busy_rises);
    else passed++;
    total++;
    if (last_busy_len !== 16) $display("[TB] FAIL glitch busy length: got %0d, expected 16", last_busy_len);
    else passed++;
    compare_bytes("glitch");
    clear_mon();
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 32);
    tick(64);
    compare_bytes("after glitch");
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_frame(8'h3C, 1'b0, 32);
    tick(32 * 19);
    total++;
    if (fe_pulses !== 1) $display("[TB] FAIL frame error pulses: got %0d, expected 1", fe_pulses);
    else passed++;
    total++;
    if (fe_high !== 1) $display("[TB] FAIL frame error width: got %0d clk, expected 1", fe_high);
    else passed++;
    total++;
    if (ov_pulses !== 0) $display("[TB] FAIL frame error overrun: got %0d pulses, expected 0", ov_pulses);
    else passed++;
    total++;
    if (busy_rises !== 1) $display("[TB] FAIL frame error rearm while low: got %0d busy rises, expected 1", busy_rises);
    else passed++;
    compare_bytes("frame error");
    rxd = 1'b1;
    tick(64);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 32);
    tick(64);
    compare_bytes("after break");
  endtask

  task automatic test_overrun();
    clear_mon();
    tready = 1'b0;
    send_frame(8'h11, 1'b1, 32);
    tick(32);
    send_frame(8'h22, 1'b1, 32);
    tick(32);
    total++;
    if (ov_pulses !== 1) $display("[TB] FAIL overrun pulses: got %0d, expected 1", ov_pulses);
    else passed++;
    total++;
    if (ov_high !== 1) $display("[TB] FAIL overrun width: got %0d clk, expected 1", ov_high);
    else passed++;
    total++;
    if (fe_pulses !== 0) $display("[TB] FAIL overrun frame_error: got %0d pulses, expected 0", fe_pulses);
    else passed++;
    total++;
    if (tvalid !== 1'b1) $display("[TB] FAIL overrun tvalid held: got %b, expected 1", tvalid);
    else passed++;
    total++;
    if (tdata !== 8'h22) $display("[TB] FAIL overrun tdata held: got %h, expected 22", tdata);
    else passed++;
    tready = 1'b1;
    tick(6);
    exp_q.push_back(8'h22);
    compare_bytes("overrun drain");
    total++;
    if (tvalid !== 1'b0) $display("[TB] FAIL overrun tvalid after drain: got %b, expected 0", tvalid);
    else passed++;
  endtask

  task automatic test_baud_tolerance();
    int skew [2] = '{124, 132};
    prescale = 16'd16;
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, skew[k]);
      tick(2 * skew[k]);
      compare_bytes($sformatf("tolerance %0d clk/bit", skew[k]));
      check_no_errors($sformatf("tolerance %0d clk/bit", skew[k]));
    end
    prescale = 16'd4;
  endtask

  task automatic test_prescale_zero();
    clear_mon();
    prescale = 16'd0;
    send_frame(8'h99, 1'b1, 32);
    tick(64);
    total++;
    if (busy_rises !== 0) $display("[TB] FAIL prescale zero busy rises: got %0d, expected 0", busy_rises);
    else passed++;
    compare_bytes("prescale zero");
    prescale = 16'd4;
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    rxd = 1'b0;
    tick(32);
    rxd = 1'b1;
    tick(32 * 3);
    rst_n = 1'b0;
    tick(3);
    check_outputs_zero("mid-frame reset");
    rst_n = 1'b1;
    tick(32 * 8);
    compare_bytes("aborted frame");
    clear_mon();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 32);
    tick(64);
    compare_bytes("after reset");
    check_no_errors("after reset");
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    int p;
    clear_mon();
    tready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      p        = int'($urandom_range(1, 6));
      prescale = 16'(p);
      b        = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, 8 * p);
      tick(8 * p * int'($urandom_range(0, 2)));
    end
    tick(100);
    compare_bytes("random");
    check_no_errors("random");
    prescale = 16'd4;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_start_glitch();
    test_frame_error();
    test_overrun();
    test_baud_tolerance();
    test_prescale_zero();
    test_reset_mid_frame();
    test_random_frames();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
